regfile_sb: RTL

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_pkg.sv | 15 +
 rtl/rf_scoreboard.sv | 48 ++++
 rtl/regfile_sb.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file.
//   rf_state_e        : sweep controller state (IDLE, CLEAR)
//   RF_*_DEFAULT      : default values for the regfile_sb parameters
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_e;

  localparam int RF_WIDTH_DEFAULT     = 8;
  localparam int RF_DEPTH_DEFAULT     = 8;
  localparam int RF_ZERO_REG0_DEFAULT = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one bit per register marking a pending producer.
// Ports:
//   CLK, Reset            clock, asynchronous active-high reset
//   set_en_i/set_addr_i   producer issued: mark register busy
//   clr_en_i/clr_addr_i   result written: mark register free
//   sweep_en_i/addr_i     clear sweep: force register free
//   busy_o                current busy bits, one per register
module rf_scoreboard #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             set_en_i,
  input  logic [AW-1:0]    set_addr_i,
  input  logic             clr_en_i,
  input  logic [AW-1:0]    clr_addr_i,
  input  logic             sweep_en_i,
  input  logic [AW-1:0]    sweep_addr_i,
  output logic [DEPTH-1:0] busy_o
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_busy
      // Sweep beats everything; a new producer beats a completing write
      // to the same register so the new result is still waited for.
      assign busy_d[gi] = (sweep_en_i && sweep_addr_i == AW'(gi)) ? 1'b0 :
                          (set_en_i   && set_addr_i   == AW'(gi)) ? 1'b1 :
                          (clr_en_i   && clr_addr_i   == AW'(gi)) ? 1'b0 :
                          busy_q[gi];
    end
  endgenerate

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-read, one-write register file with write-through bypass, zero flags,
// a busy-bit scoreboard and a multi-cycle clear sweep.
// Ports:
//   CLK, Reset                 clock, asynchronous active-high reset
//   rdAddrA/B                  read addresses (combinational reads)
//   valA/B, zeroA/B, busyA/B   read data, data==0, pending producer
//   wrEn, wrAddr, wrData       write port (commits in IDLE only)
//   issueEn, issueAddr         mark a register busy
//   clrReq / clrBusy           start clear sweep / sweep in progress
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH     = RF_WIDTH_DEFAULT,
  parameter int DEPTH     = RF_DEPTH_DEFAULT,
  parameter int ZERO_REG0 = RF_ZERO_REG0_DEFAULT,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [AW-1:0]    rdAddrA,
  input  logic [AW-1:0]    rdAddrB,
  output logic [WIDTH-1:0] valA,
  output logic [WIDTH-1:0] valB,
  output logic             zeroA,
  output logic             zeroB,
  output logic             busyA,
  output logic             busyB,
  input  logic             wrEn,
  input  logic [AW-1:0]    wrAddr,
  input  logic [WIDTH-1:0] wrData,
  input  logic             issueEn,
  input  logic [AW-1:0]    issueAddr,
  input  logic             clrReq,
  output logic             clrBusy
);

  rf_state_e        state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] busy;

  logic idle;
  logic wr_commit;
  logic iss_commit;
  logic sweep_en;
  logic rd0_a, rd0_b;
  logic byp_a, byp_b;

  assign idle     = (state_q == IDLE);
  assign sweep_en = (state_q == CLEAR);

  // Register 0 swallows writes and issues when it is hardwired to zero.
  assign wr_commit  = wrEn    && idle && !(ZERO_REG0 != 0 && wrAddr    == '0);
  assign iss_commit = issueEn && idle && !(ZERO_REG0 != 0 && issueAddr == '0);

  // ---------------------------------------------------------------------
  // Sweep controller
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clrReq) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        // Pointer wraps back to 0 on the last step, ready for the next sweep.
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Register array
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_mem
      assign mem_d[gi] = (sweep_en  && ptr_q  == AW'(gi)) ? '0     :
                         (wr_commit && wrAddr == AW'(gi)) ? wrData :
                         mem_q[gi];
    end
  endgenerate

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  rf_scoreboard #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_scoreboard (
    .CLK          (CLK),
    .Reset        (Reset),
    .set_en_i     (iss_commit),
    .set_addr_i   (issueAddr),
    .clr_en_i     (wr_commit),
    .clr_addr_i   (wrAddr),
    .sweep_en_i   (sweep_en),
    .sweep_addr_i (ptr_q),
    .busy_o       (busy)
  );

  // ---------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------
  assign rd0_a = (ZERO_REG0 != 0) && (rdAddrA == '0);
  assign rd0_b = (ZERO_REG0 != 0) && (rdAddrB == '0);

  // wr_commit is already false during the sweep, so no bypass there.
  assign byp_a = wr_commit && (wrAddr == rdAddrA);
  assign byp_b = wr_commit && (wrAddr == rdAddrB);

  assign valA = rd0_a ? '0 : (byp_a ? wrData : mem_q[rdAddrA]);
  assign valB = rd0_b ? '0 : (byp_b ? wrData : mem_q[rdAddrB]);

  assign zeroA = (valA == '0);
  assign zeroB = (valB == '0);

  // A bypassing write is the producer completing, so the reader sees free.
  assign busyA = busy[rdAddrA] && !byp_a && !rd0_a;
  assign busyB = busy[rdAddrB] && !byp_b && !rd0_b;

  assign clrBusy = sweep_en;

endmodule
